gb_irq_ctrl: RTL and testbench

- Parametrised interrupt controller that replaces the single-bit interrupt_enable flop in the top level.
- Holds the IE (0xFFFF) and IF (0xFF0F) registers, latches requests from up to NUM_IRQ peripheral sources, and priority-encodes pending interrupts.
- Presents a registered pending flag plus vector to the cpu, and clears the serviced bit on a one-cycle acknowledge.
- Sits on the cpu memory bus beside wram/hram/ppu with the usual data_r/data_active read-mux contract.

---
 rtl/gb_pkg.sv | 22 ++
 rtl/gb_irq_prio_enc.sv | 24 ++
 rtl/gb_irq_ctrl.sv | 128 ++++++++++++
 tb/tb_gb_irq_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// gb_pkg: constants shared by the Game Boy top level and its bus peripherals.
//   - IE/IF bus addresses used by the interrupt controller.
//   - Interrupt source indices (bit position == priority, 0 is highest).
//   - Default interrupt controller geometry.
package gb_pkg;

  localparam logic [15:0] IE_ADDR = 16'hFFFF;
  localparam logic [15:0] IF_ADDR = 16'hFF0F;

  localparam int          NUM_IRQ_DEFAULT    = 5;
  localparam logic [15:0] VEC_BASE_DEFAULT   = 16'h0040;
  localparam int          VEC_STRIDE_DEFAULT = 8;

  typedef enum logic [2:0] {
    IRQ_VBLANK = 3'd0,
    IRQ_STAT   = 3'd1,
    IRQ_TIMER  = 3'd2,
    IRQ_SERIAL = 3'd3,
    IRQ_JOYPAD = 3'd4
  } gb_irq_e;

endpackage

// File: rtl/gb_irq_prio_enc.sv
// gb_irq_prio_enc: lowest-set-bit priority encoder, purely combinational.
// Ports:
//   req    in  NUM_IRQ  request vector, bit 0 has highest priority
//   valid  out 1        some request bit is set
//   index  out 3        index of lowest set bit, 0 when none
module gb_irq_prio_enc #(
  parameter int NUM_IRQ = gb_pkg::NUM_IRQ_DEFAULT
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [2:0]         index
);

  // Scan from the lowest-priority bit upward so the last hit wins,
  // leaving the lowest set bit in index.
  always_comb begin
    valid = |req;
    index = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = 3'(i);
    end
  end

endmodule

// File: rtl/gb_irq_ctrl.sv
// gb_irq_ctrl: IE/IF interrupt controller on the cpu memory bus.
// Latches edge- or level-triggered peripheral requests into IF, masks them
// with IE and presents a registered pending flag, index and vector.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   addr         cpu bus address
//   data_w       cpu write data
//   do_write     cpu write strobe
//   data_r       combinational read data (8'hFF when not addressed)
//   data_active  high when addr selects IE or IF
//   irq_src      peripheral request lines (clk domain)
//   irq_pending  registered: some enabled request is pending
//   irq_index    registered: highest-priority pending source
//   irq_vector   registered: vector of irq_index
//   irq_ack      one-cycle pulse: cpu has taken irq_index
module gb_irq_ctrl
  import gb_pkg::*;
#(
  parameter int               NUM_IRQ    = NUM_IRQ_DEFAULT,
  parameter logic [15:0]      IE_ADDR    = gb_pkg::IE_ADDR,
  parameter logic [15:0]      IF_ADDR    = gb_pkg::IF_ADDR,
  parameter logic [15:0]      VEC_BASE   = VEC_BASE_DEFAULT,
  parameter int               VEC_STRIDE = VEC_STRIDE_DEFAULT,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        addr,
  input  logic [7:0]         data_w,
  input  logic               do_write,
  output logic [7:0]         data_r,
  output logic               data_active,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq_pending,
  output logic [2:0]         irq_index,
  output logic [15:0]        irq_vector,
  input  logic               irq_ack
);

  logic [7:0]         ie_q, ie_d;
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [NUM_IRQ-1:0] src_prev_q, src_prev_d;
  logic               irq_pending_q, irq_pending_d;
  logic [2:0]         irq_index_q, irq_index_d;
  logic [15:0]        irq_vector_q, irq_vector_d;

  logic [NUM_IRQ-1:0] set_term;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [NUM_IRQ-1:0] masked_n;
  logic [7:0]         if_view;
  logic               enc_valid;
  logic [2:0]         enc_index;

  // Edge sources fire only on a low-to-high transition; level sources
  // re-assert every cycle the line is high.
  always_comb begin
    set_term   = (irq_src & ~src_prev_q & EDGE_MASK) | (irq_src & ~EDGE_MASK);
    src_prev_d = irq_src;
  end

  // IE/IF next state. The ack only clears a bit the cpu could actually
  // have seen, and new requests are ORed in last so a request arriving in
  // the same cycle as a write or ack of its bit is never lost.
  always_comb begin
    ie_d = ie_q;
    if (do_write && addr == IE_ADDR) ie_d = data_w;

    if_d = if_q;
    if (do_write && addr == IF_ADDR) if_d = data_w[NUM_IRQ-1:0];
    ack_mask = NUM_IRQ'(1) << irq_index_q;
    if (irq_ack && irq_pending_q) if_d = if_d & ~ack_mask;
    if_d = if_d | set_term;
  end

  // Encode from next-state values so pending and vector appear in the
  // same cycle the new IF is visible on the bus.
  assign masked_n = ie_d[NUM_IRQ-1:0] & if_d;

  gb_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req   (masked_n),
    .valid (enc_valid),
    .index (enc_index)
  );

  always_comb begin
    irq_pending_d = enc_valid;
    irq_index_d   = enc_index;
    irq_vector_d  = VEC_BASE + 16'(enc_index) * 16'(VEC_STRIDE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q          <= 8'h00;
      if_q          <= '0;
      src_prev_q    <= '0;
      irq_pending_q <= 1'b0;
      irq_index_q   <= 3'd0;
      irq_vector_q  <= VEC_BASE;
    end else begin
      ie_q          <= ie_d;
      if_q          <= if_d;
      src_prev_q    <= src_prev_d;
      irq_pending_q <= irq_pending_d;
      irq_index_q   <= irq_index_d;
      irq_vector_q  <= irq_vector_d;
    end
  end

  // Unimplemented IF bits read back as 1, matching the original hardware.
  always_comb begin
    if_view = 8'hFF;
    if_view[NUM_IRQ-1:0] = if_q;
  end

  always_comb begin
    data_active = (addr == IE_ADDR) || (addr == IF_ADDR);
    data_r      = 8'hFF;
    if (addr == IE_ADDR)      data_r = ie_q;
    else if (addr == IF_ADDR) data_r = if_view;
  end

  assign irq_pending = irq_pending_q;
  assign irq_index   = irq_index_q;
  assign irq_vector  = irq_vector_q;

endmodule

// File: tb/tb_gb_irq_ctrl.sv
// tb_gb_irq_ctrl: directed self-checking bench for gb_irq_ctrl.
// Two instances share the cpu bus: dut uses the default all-edge sources,
// dut_lvl makes source 0 level triggered.
module tb_gb_irq_ctrl;
  import gb_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  data_w;
  logic        do_write;

  logic [4:0]  irq_src, irq_src_lvl;
  logic        irq_ack, irq_ack_lvl;

  logic [7:0]  data_r, data_r_lvl;
  logic        data_active, data_active_lvl;
  logic        irq_pending, irq_pending_lvl;
  logic [2:0]  irq_index, irq_index_lvl;
  logic [15:0] irq_vector, irq_vector_lvl;

  int checks = 0;
  int errors = 0;

  gb_irq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .data_w      (data_w),
    .do_write    (do_write),
    .data_r      (data_r),
    .data_active (data_active),
    .irq_src     (irq_src),
    .irq_pending (irq_pending),
    .irq_index   (irq_index),
    .irq_vector  (irq_vector),
    .irq_ack     (irq_ack)
  );

  gb_irq_ctrl #(
    .EDGE_MASK (5'b11110)
  ) dut_lvl (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .data_w      (data_w),
    .do_write    (do_write),
    .data_r      (data_r_lvl),
    .data_active (data_active_lvl),
    .irq_src     (irq_src_lvl),
    .irq_pending (irq_pending_lvl),
    .irq_index   (irq_index_lvl),
    .irq_vector  (irq_vector_lvl),
    .irq_ack     (irq_ack_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle: drive write/ack, clock once, then release the strobes.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic wr,
                               input logic ack, input logic ack_lvl);
    addr        = a;
    data_w      = d;
    do_write    = wr;
    irq_ack     = ack;
    irq_ack_lvl = ack_lvl;
    tick();
    do_write    = 1'b0;
    irq_ack     = 1'b0;
    irq_ack_lvl = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [15:0] a, input logic [7:0] exp);
    addr     = a;
    do_write = 1'b0;
    #1;
    checkOutput(tag, 16'(data_r), 16'(exp));
  endtask

  initial begin
    reset       = 1'b1;
    addr        = 16'h0000;
    data_w      = 8'h00;
    do_write    = 1'b0;
    irq_src     = 5'b0;
    irq_src_lvl = 5'b0;
    irq_ack     = 1'b0;
    irq_ack_lvl = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    readCheck("rst_ie", IE_ADDR, 8'h00);
    checkOutput("rst_active_ie", 16'(data_active), 16'd1);
    readCheck("rst_if", IF_ADDR, 8'hE0);
    checkOutput("rst_active_if", 16'(data_active), 16'd1);
    readCheck("unmapped", 16'h1234, 8'hFF);
    checkOutput("unmapped_active", 16'(data_active), 16'd0);
    checkOutput("rst_pending", 16'(irq_pending), 16'd0);
    checkOutput("rst_index", 16'(irq_index), 16'd0);
    checkOutput("rst_vector", irq_vector, 16'h0040);

    // Ack while nothing is pending is ignored: IF bit set but IE masks it
    applyStimulus(IF_ADDR, 8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(IF_ADDR, 8'h00, 1'b0, 1'b1, 1'b0);
    readCheck("ack_no_pending", IF_ADDR, 8'hE1);
    checkOutput("masked_pending", 16'(irq_pending), 16'd0);
    applyStimulus(IF_ADDR, 8'h00, 1'b1, 1'b0, 1'b0);
    readCheck("if_clear", IF_ADDR, 8'hE0);

    // Single timer pulse with IE=05
    applyStimulus(IE_ADDR, 8'h05, 1'b1, 1'b0, 1'b0);
    readCheck("ie_05", IE_ADDR, 8'h05);
    irq_src[IRQ_TIMER] = 1'b1;
    tick();
    irq_src = 5'b0;
    readCheck("timer_if", IF_ADDR, 8'hE4);
    checkOutput("timer_pending", 16'(irq_pending), 16'd1);
    checkOutput("timer_index", 16'(irq_index), 16'd2);
    checkOutput("timer_vector", irq_vector, 16'h0050);
    applyStimulus(IF_ADDR, 8'h00, 1'b0, 1'b1, 1'b0);
    readCheck("timer_ack_if", IF_ADDR, 8'hE0);
    checkOutput("timer_ack_pending", 16'(irq_pending), 16'd0);

    // Simultaneous joypad and stat, served in priority order
    applyStimulus(IE_ADDR, 8'h1F, 1'b1, 1'b0, 1'b0);
    irq_src = 5'b10010;
    tick();
    irq_src = 5'b0;
    checkOutput("dual_vector", irq_vector, 16'h0048);
    checkOutput("dual_index", 16'(irq_index), 16'd1);
    applyStimulus(IF_ADDR, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("dual_ack1_vector", irq_vector, 16'h0060);
    readCheck("dual_ack1_if", IF_ADDR, 8'hF0);
    checkOutput("dual_ack1_pending", 16'(irq_pending), 16'd1);
    applyStimulus(IF_ADDR, 8'h00, 1'b0, 1'b1, 1'b0);
    checkOutput("dual_ack2_pending", 16'(irq_pending), 16'd0);
    readCheck("dual_ack2_if", IF_ADDR, 8'hE0);
    checkOutput("dual_ack2_vector", irq_vector, 16'h0040);

    // Held source 0: edge mode fires once, level mode re-sets after ack
    irq_src[IRQ_VBLANK]     = 1'b1;
    irq_src_lvl[IRQ_VBLANK] = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("hold_edge_pending", 16'(irq_pending), 16'd1);
    checkOutput("hold_lvl_pending", 16'(irq_pending_lvl), 16'd1);
    applyStimulus(IF_ADDR, 8'h00, 1'b0, 1'b1, 1'b1);
    readCheck("hold_edge_if", IF_ADDR, 8'hE0);
    checkOutput("hold_lvl_if", 16'(data_r_lvl), 16'h00E1);
    checkOutput("hold_lvl_pending2", 16'(irq_pending_lvl), 16'd1);
    for (int i = 0; i < 5; i++) tick();
    readCheck("hold_edge_noretrig", IF_ADDR, 8'hE0);
    checkOutput("hold_edge_pending2", 16'(irq_pending), 16'd0);
    irq_src     = 5'b0;
    irq_src_lvl = 5'b0;
    applyStimulus(IF_ADDR, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("lvl_release_if", 16'(data_r_lvl), 16'h00E0);

    // IF write colliding with a serial edge: the edge wins
    irq_src[IRQ_SERIAL] = 1'b1;
    applyStimulus(IF_ADDR, 8'h00, 1'b1, 1'b0, 1'b0);
    readCheck("wr_vs_edge_if", IF_ADDR, 8'hE8);
    checkOutput("wr_vs_edge_vector", irq_vector, 16'h0058);
    irq_src = 5'b0;
    tick();
    // Ack of bit 3 coincident with a fresh edge on bit 3
    irq_src[IRQ_SERIAL] = 1'b1;
    applyStimulus(IF_ADDR, 8'h00, 1'b0, 1'b1, 1'b0);
    readCheck("ack_vs_edge_if", IF_ADDR, 8'hE8);
    checkOutput("ack_vs_edge_pending", 16'(irq_pending), 16'd1);
    checkOutput("ack_vs_edge_index", 16'(irq_index), 16'd3);
    irq_src = 5'b0;

    // Reset mid-operation discards everything
    applyStimulus(IE_ADDR, 8'hFF, 1'b1, 1'b0, 1'b0);
    readCheck("ie_ff", IE_ADDR, 8'hFF);
    checkOutput("pre_reset_pending", 16'(irq_pending), 16'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_pending", 16'(irq_pending), 16'd0);
    readCheck("mid_rst_ie", IE_ADDR, 8'h00);
    readCheck("mid_rst_if", IF_ADDR, 8'hE0);
    checkOutput("mid_rst_vector", irq_vector, 16'h0040);
    checkOutput("mid_rst_index", 16'(irq_index), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
